// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO sitting behind the UART receiver.
// Acknowledges receiver bytes combinationally, drives a registered RTS level and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS   = 8,
    parameter int DEPTH          = 4,
    parameter int RTS_LEVEL      = DEPTH - 1,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rx_valid,
    input  logic [PAYLOAD_BITS-1:0]    rx_data,
    output logic                       rx_read,
    input  logic                       rd_en,
    output logic [PAYLOAD_BITS-1:0]    rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    input  logic                       clear_overrun,
    output logic                       fifo_rts
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RTS_CNT  = CNT_W'(RTS_LEVEL);

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overrun_q, overrun_d;
    logic                    rts_q, rts_d;
    logic                    pop, full, space, push, drop;

    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        pop   = rd_en && (count_q != '0);
        full  = (count_q == FULL_CNT);
        space = !full || pop;
        // A byte is never acknowledged while reset is asserted.
        push  = resetn && rx_valid && space;
        drop  = resetn && (DROP_WHEN_FULL != 0) && rx_valid && !space;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (clear_overrun) overrun_d = 1'b0;
        if (drop)          overrun_d = 1'b1;

        rts_d = (count_d >= RTS_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
        end
    end

    // NOTE: storage has no reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rx_read  = push || drop;
    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign fifo_rts = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a hold-off instance and a drop-when-full instance.
// Inputs change 2ns after each rising edge; outputs are checked 1ns later, well away from the edge.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Hold-off instance (DROP_WHEN_FULL = 0)
    logic       resetn, rx_valid, rd_en, clear_overrun;
    logic [7:0] rx_data;
    logic       rx_read, rd_valid, overrun, fifo_rts;
    logic [7:0] rd_data;
    logic [2:0] count;

    // Drop-when-full instance
    logic       d_resetn, d_rx_valid, d_rd_en, d_clear_overrun;
    logic [7:0] d_rx_data;
    logic       d_rx_read, d_rd_valid, d_overrun, d_fifo_rts;
    logic [7:0] d_rd_data;
    logic [2:0] d_count;

    uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(4), .RTS_LEVEL(3), .DROP_WHEN_FULL(0)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_read(rx_read), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overrun(overrun), .clear_overrun(clear_overrun), .fifo_rts(fifo_rts)
    );

    uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(4), .RTS_LEVEL(3), .DROP_WHEN_FULL(1)) dut_drop (
        .clk(clk), .resetn(d_resetn), .rx_valid(d_rx_valid), .rx_data(d_rx_data),
        .rx_read(d_rx_read), .rd_en(d_rd_en), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
        .count(d_count), .overrun(d_overrun), .clear_overrun(d_clear_overrun), .fifo_rts(d_fifo_rts)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs may be changed on return.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0; clear_overrun = 1'b0;
        d_resetn = 1'b0; d_rx_valid = 1'b0; d_rx_data = 8'h00; d_rd_en = 1'b0; d_clear_overrun = 1'b0;

        // ---- reset state ----
        tick(); tick(); settle();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count",    count,    0);
        check("rst_overrun",  overrun,  0);
        check("rst_rts",      fifo_rts, 1);
        check("rst_rd_data",  rd_data,  0);
        check("rst_rx_read",  rx_read,  0);

        resetn = 1'b1; d_resetn = 1'b1;
        tick(); settle();
        check("rts_after_release", fifo_rts, 0);

        // ---- single push / pop of 0xA5 ----
        rx_valid = 1'b1; rx_data = 8'hA5; settle();
        check("a5_rx_read", rx_read, 1);
        tick(); rx_valid = 1'b0; settle();
        check("a5_rd_valid", rd_valid, 1);
        check("a5_rd_data",  rd_data,  8'hA5);
        check("a5_count",    count,    1);
        check("a5_rx_read_idle", rx_read, 0);
        rd_en = 1'b1;
        tick(); rd_en = 1'b0; settle();
        check("a5_pop_rd_valid", rd_valid, 0);
        check("a5_pop_count",    count,    0);
        check("a5_pop_rd_data",  rd_data,  0);

        // ---- fill to full, hold off 5th byte ----
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i); settle();
            check($sformatf("fill%0d_rx_read", i), rx_read, 1);
            tick(); rx_valid = 1'b0; settle();
            check($sformatf("fill%0d_count", i), count, 32'(i));
            check($sformatf("fill%0d_rts", i), fifo_rts, (i >= 3) ? 1 : 0);
        end
        rx_valid = 1'b1; rx_data = 8'h05; settle();
        check("full_hold_rx_read", rx_read, 0);
        tick(); settle();
        check("full_hold_count",   count,   4);
        check("full_hold_rx_read2", rx_read, 0);
        check("full_head", rd_data, 8'h01);
        rd_en = 1'b1; settle();
        check("pop_frees_rx_read", rx_read, 1);
        tick(); rd_en = 1'b0; rx_valid = 1'b0; settle();
        check("pop_push_count", count, 4);
        check("pop_push_rts",   fifo_rts, 1);
        for (int e = 2; e <= 5; e++) begin
            check($sformatf("drain_valid_%0d", e), rd_valid, 1);
            check($sformatf("drain_data_%0d", e),  rd_data,  32'(e));
            rd_en = 1'b1;
            tick(); rd_en = 1'b0; settle();
        end
        check("drained_count", count,    0);
        check("drained_valid", rd_valid, 0);
        check("drained_rts",   fifo_rts, 0);

        // ---- rd_en while empty ----
        rd_en = 1'b1;
        tick(); rd_en = 1'b0; settle();
        check("empty_rd_count",   count,    0);
        check("empty_rd_valid",   rd_valid, 0);
        check("empty_rd_data",    rd_data,  0);
        check("empty_rd_overrun", overrun,  0);

        // ---- simultaneous push/pop across pointer wrap ----
        rx_valid = 1'b1; rx_data = 8'h10;
        tick(); settle();
        check("wrap_prime_count", count, 1);
        for (int k = 1; k <= 10; k++) begin
            rx_data = 8'h10 + 8'(k); rd_en = 1'b1; settle();
            check($sformatf("wrap%0d_head", k),    rd_data, 32'h10 + 32'(k) - 1);
            check($sformatf("wrap%0d_rx_read", k), rx_read, 1);
            tick(); settle();
            check($sformatf("wrap%0d_count", k),   count,   1);
        end
        rx_valid = 1'b0; rd_en = 1'b0; settle();
        check("wrap_last_head", rd_data, 8'h1A);
        rd_en = 1'b1;
        tick(); rd_en = 1'b0; settle();
        check("wrap_end_count", count, 0);

        // ---- reset mid-operation with a pending byte ----
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = 8'h31 + 8'(i);
            tick();
        end
        rx_valid = 1'b0; settle();
        check("pre_rst_count", count,    3);
        check("pre_rst_rts",   fifo_rts, 1);
        rx_valid = 1'b1; rx_data = 8'h44; resetn = 1'b0; settle();
        check("in_rst_rx_read", rx_read, 0);
        tick(); settle();
        check("mid_rst_count",   count,    0);
        check("mid_rst_valid",   rd_valid, 0);
        check("mid_rst_rts",     fifo_rts, 1);
        check("mid_rst_rx_read", rx_read,  0);
        resetn = 1'b1; settle();
        check("post_rst_rx_read", rx_read, 1);
        tick(); rx_valid = 1'b0; settle();
        check("post_rst_count", count,   1);
        check("post_rst_data",  rd_data, 8'h44);

        // ---- drop-when-full instance ----
        for (int i = 0; i < 4; i++) begin
            d_rx_valid = 1'b1; d_rx_data = 8'h61 + 8'(i); settle();
            check($sformatf("dfill%0d_rx_read", i), d_rx_read, 1);
            tick();
        end
        d_rx_valid = 1'b0; settle();
        check("dfull_count",   d_count,   4);
        check("dfull_overrun", d_overrun, 0);
        d_rx_valid = 1'b1; d_rx_data = 8'h77; settle();
        check("drop_rx_read", d_rx_read, 1);
        tick(); d_rx_valid = 1'b0; settle();
        check("drop_overrun", d_overrun, 1);
        check("drop_count",   d_count,   4);
        check("drop_head",    d_rd_data, 8'h61);
        d_clear_overrun = 1'b1;
        tick(); d_clear_overrun = 1'b0; settle();
        check("clear_overrun", d_overrun, 0);
        d_clear_overrun = 1'b1; d_rx_valid = 1'b1; d_rx_data = 8'h78;
        tick(); d_clear_overrun = 1'b0; d_rx_valid = 1'b0; settle();
        check("clear_vs_drop_overrun", d_overrun, 1);
        check("clear_vs_drop_count",   d_count,   4);
        for (int e = 0; e < 4; e++) begin
            check($sformatf("ddrain_data_%0d", e), d_rd_data, 32'h61 + 32'(e));
            d_rd_en = 1'b1;
            tick(); d_rd_en = 1'b0; settle();
        end
        check("ddrained_count", d_count,    0);
        check("ddrained_valid", d_rd_valid, 0);
        check("ddrained_data",  d_rd_data,  0);
        check("ddrained_overrun_sticky", d_overrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
